// File: rtl/dct_seq_pkg.sv
// ============================================================================
// Module      : dct_seq_pkg
// Description : Shared constants and state encoding for the DCT sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dct_seq_pkg;

    localparam int N_PTS    = 8;
    localparam int IDX_W    = $clog2(N_PTS);
    localparam int PIPE_STG = 6;
    localparam int STG_W    = $clog2(PIPE_STG);
    localparam int COEF_W   = 40;
    localparam int CNT_W    = 16;
    localparam int SMP_W    = 8;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_PTS - 1);
    localparam logic [STG_W-1:0] STG_LAST = STG_W'(PIPE_STG - 1);

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_STAGE = 3'd2,
        ST_SCALE = 3'd3,
        ST_SIGN  = 3'd4,
        ST_READ  = 3'd5
    } state_t;

endpackage

`default_nettype wire

// File: rtl/dct_seq_ctrl_if.sv
// ============================================================================
// Module      : dct_seq_ctrl_if
// Description : Sample-in and coefficient-out valid/ready streams of the
//               DCT sequencer. slave = sequencer side, master = source/sink.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dct_seq_ctrl_if;
    import dct_seq_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [SMP_W-1:0]  in_data;
    logic              out_valid;
    logic              out_ready;
    logic [IDX_W-1:0]  out_idx;
    logic [COEF_W-1:0] out_coef;
    logic              out_neg;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_idx, out_coef, out_neg
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_idx, out_coef, out_neg
    );

endinterface

`default_nettype wire

// File: rtl/dct_seq_ctrl.sv
// ============================================================================
// Module      : dct_seq_ctrl
// Description : Block sequencer for the 8-point DCT datapath: clear, load 8
//               samples, flush pipeline, scale, sign-convert, stream out.
//               Optional macro DCT_SEQ_CYCCNT_EN adds the blk_cycles counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dct_seq_ctrl
    import dct_seq_pkg::*;
(
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              soft_clr,
    dct_seq_ctrl_if.slave          strm,
    output logic                   dp_clr,
    output logic                   dp_ld_en,
    output logic [IDX_W-1:0]       dp_ld_idx,
    output logic [SMP_W-1:0]       dp_ld_data,
    output logic                   dp_stage_en,
    output logic                   dp_scale_en,
    output logic                   dp_sign_en,
    output logic [IDX_W-1:0]       dp_rd_idx,
    input  wire logic [COEF_W-1:0] dp_coef,
    input  wire logic              dp_neg,
    output logic                   busy,
`ifdef DCT_SEQ_CYCCNT_EN
    output logic [CNT_W-1:0]       blk_cycles,
`endif
    output logic                   done
);

    state_t           r_state, w_state_nxt;
    logic [IDX_W-1:0] r_idx,   w_idx_nxt;
    logic [STG_W-1:0] r_stg,   w_stg_nxt;
    logic             r_done,  w_done_nxt;

    logic w_in_ready;
    logic w_out_valid;
    logic w_clr;
    logic w_stage;
    logic w_scale;
    logic w_sign;
    logic w_ld_beat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_INIT;
            r_idx   <= '0;
            r_stg   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_stg   <= w_stg_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_stg_nxt   = r_stg;
        w_done_nxt  = 1'b0;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_clr       = 1'b0;
        w_stage     = 1'b0;
        w_scale     = 1'b0;
        w_sign      = 1'b0;

        case (r_state)
            ST_INIT: begin
                w_clr       = 1'b1;
                w_idx_nxt   = '0;
                w_state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                w_in_ready = 1'b1;
                if (strm.in_valid) begin
                    if (r_idx == IDX_LAST) begin
                        w_idx_nxt   = '0;
                        w_stg_nxt   = '0;
                        w_state_nxt = ST_STAGE;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end
            ST_STAGE: begin
                w_stage = 1'b1;
                if (r_stg == STG_LAST) begin
                    w_stg_nxt   = '0;
                    w_state_nxt = ST_SCALE;
                end else begin
                    w_stg_nxt = r_stg + 1'b1;
                end
            end
            ST_SCALE: begin
                w_scale     = 1'b1;
                w_state_nxt = ST_SIGN;
            end
            ST_SIGN: begin
                w_sign      = 1'b1;
                w_idx_nxt   = '0;
                w_state_nxt = ST_READ;
            end
            ST_READ: begin
                w_out_valid = 1'b1;
                if (strm.out_ready) begin
                    if (r_idx == IDX_LAST) begin
                        w_done_nxt  = 1'b1;
                        w_idx_nxt   = '0;
                        w_state_nxt = ST_INIT;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_INIT;
            end
        endcase

        // Abort masks both handshakes so nothing is consumed in this cycle.
        if (soft_clr) begin
            w_in_ready  = 1'b0;
            w_out_valid = 1'b0;
            w_state_nxt = ST_INIT;
            w_idx_nxt   = '0;
            w_stg_nxt   = '0;
            w_done_nxt  = 1'b0;
        end
    end

    assign w_ld_beat = w_in_ready & strm.in_valid;

    assign strm.in_ready  = w_in_ready;
    assign strm.out_valid = w_out_valid;
    assign strm.out_idx   = r_idx;
    assign strm.out_coef  = dp_coef;
    assign strm.out_neg   = dp_neg;

    assign dp_clr      = w_clr;
    assign dp_ld_en    = w_ld_beat;
    assign dp_ld_idx   = r_idx;
    assign dp_ld_data  = w_ld_beat ? strm.in_data : '0;
    assign dp_stage_en = w_stage;
    assign dp_scale_en = w_scale;
    assign dp_sign_en  = w_sign;
    assign dp_rd_idx   = r_idx;
    // Idle means waiting for the first sample; forced low while in reset.
    assign busy        = rst_n & ~((r_state == ST_LOAD) && (r_idx == '0));
    assign done        = r_done;

`ifdef DCT_SEQ_CYCCNT_EN
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_blk;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_first_beat;
    logic             w_running;

    assign w_first_beat = w_ld_beat && (r_idx == '0);
    assign w_running    = !((r_state == ST_INIT) ||
                            ((r_state == ST_LOAD) && (r_idx == '0)));
    assign w_cnt_inc    = (&r_cnt) ? r_cnt : r_cnt + 1'b1;

    // The counter value already includes every cycle before the current
    // one, so the last output beat is added at capture time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_blk <= '0;
        end else if (soft_clr) begin
            r_cnt <= '0;
            r_blk <= '0;
        end else begin
            if (w_first_beat) begin
                r_cnt <= CNT_W'(1);
            end else if (w_running) begin
                r_cnt <= w_cnt_inc;
            end
            if (w_done_nxt) begin
                r_blk <= w_cnt_inc;
            end
        end
    end

    assign blk_cycles = r_blk;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dct_seq_ctrl.sv
// ============================================================================
// Module      : tb_dct_seq_ctrl
// Description : Directed self-checking bench for dct_seq_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dct_seq_ctrl;
    import dct_seq_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic soft_clr = 1'b0;
    always #5 clk = ~clk;

    dct_seq_ctrl_if strm ();

    logic              dp_clr, dp_ld_en, dp_stage_en, dp_scale_en, dp_sign_en;
    logic [IDX_W-1:0]  dp_ld_idx, dp_rd_idx;
    logic [SMP_W-1:0]  dp_ld_data;
    logic [COEF_W-1:0] dp_coef;
    logic              dp_neg, busy, done;
`ifdef DCT_SEQ_CYCCNT_EN
    logic [CNT_W-1:0]  blk_cycles;
`endif

    dct_seq_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .soft_clr    (soft_clr),
        .strm        (strm),
        .dp_clr      (dp_clr),
        .dp_ld_en    (dp_ld_en),
        .dp_ld_idx   (dp_ld_idx),
        .dp_ld_data  (dp_ld_data),
        .dp_stage_en (dp_stage_en),
        .dp_scale_en (dp_scale_en),
        .dp_sign_en  (dp_sign_en),
        .dp_rd_idx   (dp_rd_idx),
        .dp_coef     (dp_coef),
        .dp_neg      (dp_neg),
        .busy        (busy),
`ifdef DCT_SEQ_CYCCNT_EN
        .blk_cycles  (blk_cycles),
`endif
        .done        (done)
    );

    // Datapath stub: each coefficient slot holds a distinct value.
    function automatic logic [COEF_W-1:0] coef_of(input int i);
        return COEF_W'(i * 1000 + 7);
    endfunction

    assign dp_coef = coef_of(int'(dp_rd_idx));
    assign dp_neg  = dp_rd_idx[0];

    int n_checks = 0;
    int n_fail   = 0;
    int m_clr, m_stage, m_scale, m_sign, m_done;

    always @(negedge clk) begin
        #2;
        if (dp_clr)      m_clr++;
        if (dp_stage_en) m_stage++;
        if (dp_scale_en) m_scale++;
        if (dp_sign_en)  m_sign++;
        if (done)        m_done++;
    end

    task automatic clear_mon();
        m_clr = 0; m_stage = 0; m_scale = 0; m_sign = 0; m_done = 0;
    endtask

    task automatic test_reset();
        logic [8:0] g9;
        logic [2:0] g3;
        strm.in_valid = 1'b0; strm.in_data = '0; strm.out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        g9 = {dp_clr, strm.in_ready, strm.out_valid, busy, done,
              dp_stage_en, dp_scale_en, dp_sign_en, dp_ld_en};
        n_checks++;
        if (g9 !== 9'b1_0000_0000) begin
            n_fail++; $display("FAIL reset_outputs: got %b expected %b", g9, 9'b1_0000_0000);
        end
`ifdef DCT_SEQ_CYCCNT_EN
        n_checks++;
        if (blk_cycles !== '0) begin
            n_fail++; $display("FAIL reset_blk_cycles: got %0d expected 0", blk_cycles);
        end
`endif
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk); #1;
        g3 = {dp_clr, busy, strm.in_ready};
        n_checks++;
        if (g3 !== 3'b110) begin
            n_fail++; $display("FAIL init_cycle: got %b expected 110", g3);
        end
        @(negedge clk); #1;
        g3 = {dp_clr, busy, strm.in_ready};
        n_checks++;
        if (g3 !== 3'b001) begin
            n_fail++; $display("FAIL idle_after_init: got %b expected 001", g3);
        end
    endtask

    task automatic test_load();
        logic [11:0] g12, e12;
        logic [4:0]  g5, e5;
        clear_mon();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            strm.in_valid = 1'b1;
            strm.in_data  = 8'(10 * (i + 1));
            #1;
            g12 = {dp_ld_en, dp_ld_idx, dp_ld_data};
            e12 = {1'b1, IDX_W'(i), 8'(10 * (i + 1))};
            n_checks++;
            if (g12 !== e12) begin
                n_fail++; $display("FAIL load_beat%0d: got %h expected %h", i, g12, e12);
            end
        end
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            strm.in_valid = 1'b0;
            #1;
            g5 = {dp_ld_en, dp_stage_en, dp_scale_en, dp_sign_en, strm.out_valid};
            e5 = {1'b0, (k <= 6), (k == 7), (k == 8), (k == 9)};
            n_checks++;
            if (g5 !== e5) begin
                n_fail++; $display("FAIL pipe_T+%0d: got %b expected %b", k, g5, e5);
            end
            if (k == 9) begin
                n_checks++;
                if (strm.out_idx !== '0) begin
                    n_fail++; $display("FAIL first_out_idx: got %0d expected 0", strm.out_idx);
                end
            end
        end
    endtask

    task automatic test_stream();
        logic [45:0] g46, e46;
        logic [IDX_W-1:0] ei;
        logic [2:0] g3;
        logic [3:0] g4;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            strm.out_ready = 1'b1;
            #1;
            ei  = IDX_W'(i);
            g46 = {strm.out_valid, strm.out_idx, strm.out_coef, strm.out_neg, done};
            e46 = {1'b1, ei, coef_of(i), ei[0], 1'b0};
            n_checks++;
            if (g46 !== e46) begin
                n_fail++; $display("FAIL stream_beat%0d: got %h expected %h", i, g46, e46);
            end
        end
        @(negedge clk);
        strm.out_ready = 1'b0;
        #1;
        g3 = {done, dp_clr, strm.out_valid};
        n_checks++;
        if (g3 !== 3'b110) begin
            n_fail++; $display("FAIL done_pulse: got %b expected 110", g3);
        end
        @(negedge clk); #1;
        g4 = {done, dp_clr, busy, strm.in_ready};
        n_checks++;
        if (g4 !== 4'b0001) begin
            n_fail++; $display("FAIL after_done: got %b expected 0001", g4);
        end
        n_checks++;
        if (m_done != 1 || m_clr != 1 || m_stage != 6 || m_scale != 1 || m_sign != 1) begin
            n_fail++;
            $display("FAIL block_counts: got done=%0d clr=%0d stg=%0d scl=%0d sgn=%0d expected 1 1 6 1 1",
                     m_done, m_clr, m_stage, m_scale, m_sign);
        end
    endtask

    task automatic test_stall();
        int beats, oi, cyc;
        logic tog;
        logic [7:0] d;
        logic [11:0] g12, e12;
        logic [3:0] g4;
        clear_mon();
        beats = 0; cyc = 0;
        while (beats < 8 && cyc < 60) begin
            @(negedge clk);
            d = 8'(200 - beats * 17);
            strm.in_valid = (cyc % 3 != 1);
            strm.in_data  = d;
            #1;
            if (strm.in_valid) begin
                g12 = {dp_ld_en, dp_ld_idx, dp_ld_data};
                e12 = {1'b1, IDX_W'(beats), d};
                beats++;
            end else begin
                g12 = {dp_ld_en, dp_stage_en, 2'b00, dp_ld_data};
                e12 = 12'h000;
            end
            n_checks++;
            if (g12 !== e12) begin
                n_fail++; $display("FAIL gap_load_c%0d: got %h expected %h", cyc, g12, e12);
            end
            cyc++;
        end
        n_checks++;
        if (beats != 8) begin
            n_fail++; $display("FAIL gap_load_timeout: got %0d beats expected 8", beats);
        end
        oi = 0; cyc = 0; tog = 1'b1;
        while (oi < 8 && cyc < 80) begin
            @(negedge clk);
            strm.in_valid  = 1'b0;
            strm.out_ready = tog;
            #1;
            if (strm.out_valid) begin
                n_checks++;
                if (strm.out_idx !== IDX_W'(oi) || strm.out_coef !== coef_of(oi)) begin
                    n_fail++; $display("FAIL toggle_out%0d: got idx %0d coef %0d expected idx %0d coef %0d",
                                       oi, strm.out_idx, strm.out_coef, oi, coef_of(oi));
                end
                if (tog) oi++;
            end
            tog = ~tog;
            cyc++;
        end
        n_checks++;
        if (oi != 8) begin
            n_fail++; $display("FAIL toggle_timeout: got %0d beats expected 8", oi);
        end
        @(negedge clk);
        strm.out_ready = 1'b0;
        #1;
        @(negedge clk); #1;
        g4 = {done, dp_clr, busy, strm.in_ready};
        n_checks++;
        if (g4 !== 4'b0001) begin
            n_fail++; $display("FAIL stall_end_state: got %b expected 0001", g4);
        end
        n_checks++;
        if (m_done != 1 || m_clr != 1 || m_stage != 6 || m_scale != 1 || m_sign != 1) begin
            n_fail++;
            $display("FAIL stall_counts: got done=%0d clr=%0d stg=%0d scl=%0d sgn=%0d expected 1 1 6 1 1",
                     m_done, m_clr, m_stage, m_scale, m_sign);
        end
    endtask

    task automatic test_soft_clr();
        logic [1:0] g2;
        logic [2:0] g3;
        logic [IDX_W+2:0] g6, e6;
        clear_mon();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            strm.in_valid = 1'b1; strm.in_data = 8'(i + 1);
        end
        @(negedge clk);
        soft_clr = 1'b1;
        #1;
        g2 = {strm.in_ready, dp_ld_en};
        n_checks++;
        if (g2 !== 2'b00 || dp_ld_idx !== IDX_W'(4)) begin
            n_fail++; $display("FAIL clr_load_hs: got %b idx %0d expected 00 idx 4", g2, dp_ld_idx);
        end
        @(negedge clk);
        soft_clr = 1'b0; strm.in_valid = 1'b0;
        #1;
        g3 = {dp_clr, busy, done};
        n_checks++;
        if (g3 !== 3'b110) begin
            n_fail++; $display("FAIL clr_load_init: got %b expected 110", g3);
        end
        @(negedge clk); #1;
        g6 = {dp_clr, busy, strm.in_ready, dp_ld_idx};
        e6 = {3'b001, IDX_W'(0)};
        n_checks++;
        if (g6 !== e6) begin
            n_fail++; $display("FAIL clr_load_idle: got %b expected %b", g6, e6);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            strm.in_valid = 1'b1; strm.in_data = 8'(i + 33);
        end
        @(negedge clk);
        strm.in_valid = 1'b0;
        repeat (7) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            strm.out_ready = 1'b1;
        end
        @(negedge clk);
        soft_clr = 1'b1;
        #1;
        n_checks++;
        if (strm.out_valid !== 1'b0 || strm.out_idx !== IDX_W'(3)) begin
            n_fail++; $display("FAIL clr_read_hs: got valid %b idx %0d expected valid 0 idx 3",
                               strm.out_valid, strm.out_idx);
        end
        @(negedge clk);
        soft_clr = 1'b0; strm.out_ready = 1'b0;
        #1;
        g3 = {dp_clr, done, strm.out_valid};
        n_checks++;
        if (g3 !== 3'b100) begin
            n_fail++; $display("FAIL clr_read_init: got %b expected 100", g3);
        end
        @(negedge clk); #1;
        n_checks++;
        if ({busy, strm.in_ready} !== 2'b01 || m_done != 0) begin
            n_fail++; $display("FAIL clr_read_idle: got busy/rdy %b done_cnt %0d expected 01 0",
                               {busy, strm.in_ready}, m_done);
        end
    endtask

`ifdef DCT_SEQ_CYCCNT_EN
    task automatic run_block(input int n_low, output int acc);
        int lows, cyc;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            strm.in_valid = 1'b1; strm.in_data = 8'(i);
        end
        @(negedge clk);
        strm.in_valid = 1'b0;
        repeat (7) @(negedge clk);
        acc = 0; lows = 0; cyc = 0;
        while (acc < 8 && cyc < 100) begin
            @(negedge clk);
            strm.out_ready = (lows >= n_low);
            #1;
            if (strm.out_valid && strm.out_ready) acc++;
            else if (strm.out_valid) lows++;
            cyc++;
        end
    endtask

    task automatic test_cyccnt();
        int acc;
        int exp_cnt [2] = '{24, 29};
        int n_low   [2] = '{0, 5};
        for (int b = 0; b < 2; b++) begin
            run_block(n_low[b], acc);
            @(negedge clk);
            strm.out_ready = 1'b0;
            #1;
            n_checks++;
            if (acc != 8 || done !== 1'b1 || blk_cycles !== CNT_W'(exp_cnt[b])) begin
                n_fail++; $display("FAIL blk_cycles_%0d: got %0d (beats %0d done %b) expected %0d",
                                   b, blk_cycles, acc, done, exp_cnt[b]);
            end
            @(negedge clk);
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_load();
        test_stream();
        test_stall();
        test_soft_clr();
`ifdef DCT_SEQ_CYCCNT_EN
        test_cyccnt();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
